// File: rtl/exec_writeback_stage.sv
// rtl/exec_writeback_stage.sv - execute/write-back stage with forwarding and iterative multiply
module exec_writeback_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [4:0]  src_a,
  input  logic [4:0]  src_b,
  input  logic [4:0]  dst,
  input  logic [15:0] imm,
  input  logic        use_imm,
  output logic [4:0]  rdAddrA,
  output logic [4:0]  rdAddrB,
  input  logic [63:0] rdDataA,
  input  logic [63:0] rdDataB,
  output logic [4:0]  wrAddr,
  output logic [63:0] wrData,
  output logic        write,
  output logic        mul_busy
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [3:0] OP_MUL = 4'd10;

  state_t      state, stateNext;
  logic [5:0]  count;
  logic [63:0] mulA, mulB, acc, mulSum;
  logic [4:0]  mulDst;
  logic [63:0] opA, opB, immExt, aluResult;
  logic        accept, isMul, isLegal;

  assign rdAddrA  = src_a;
  assign rdAddrB  = src_b;
  assign in_ready = !reset && (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign isMul    = (op == OP_MUL);
  assign isLegal  = (op <= OP_MUL);

  // The pending write-back has not reached the regfile yet, so bypass it
  assign immExt = {{48{imm[15]}}, imm};
  assign opA    = (write && wrAddr == src_a) ? wrData : rdDataA;
  assign opB    = use_imm ? immExt : ((write && wrAddr == src_b) ? wrData : rdDataB);

  always_comb begin
    aluResult = 64'd0;
    case (op)
      4'd0: aluResult = opA + opB;
      4'd1: aluResult = opA - opB;
      4'd2: aluResult = opA & opB;
      4'd3: aluResult = opA | opB;
      4'd4: aluResult = opA ^ opB;
      4'd5: aluResult = opA << opB[5:0];
      4'd6: aluResult = opA >> opB[5:0];
      4'd7: aluResult = $unsigned($signed(opA) >>> opB[5:0]);
      4'd8: aluResult = {63'd0, $signed(opA) < $signed(opB)};
      4'd9: aluResult = opB;
      default: aluResult = 64'd0;
    endcase
  end

  // Shift-add: mulA walks left, mulB right; bit 0 of mulB gates the add
  assign mulSum = acc + (mulB[0] ? mulA : 64'd0);

  always_comb begin
    stateNext = state;
    mul_busy  = 1'b0;
    case (state)
      IDLE: if (accept && isMul) stateNext = MUL;
      MUL: begin
        mul_busy = 1'b1;
        if (count == 6'd63) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write  <= 1'b0;
      wrAddr <= 5'd0;
      wrData <= 64'd0;
      count  <= 6'd0;
    end else begin
      write <= 1'b0;
      if (accept) begin
        if (isMul) begin
          mulA   <= opA;
          mulB   <= opB;
          acc    <= 64'd0;
          mulDst <= dst;
          count  <= 6'd0;
        end else if (isLegal) begin
          write  <= 1'b1;
          wrAddr <= dst;
          wrData <= aluResult;
        end
      end else if (state == MUL) begin
        acc   <= mulSum;
        mulA  <= mulA << 1;
        mulB  <= mulB >> 1;
        count <= count + 6'd1;
        if (count == 6'd63) begin
          write  <= 1'b1;
          wrAddr <= mulDst;
          wrData <= mulSum;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_writeback_stage.sv
// tb/tb_exec_writeback_stage.sv - directed self-checking bench for exec_writeback_stage
module tb_exec_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [4:0]  src_a, src_b, dst;
  logic [15:0] imm;
  logic        use_imm;
  logic [4:0]  rdAddrA, rdAddrB;
  logic [63:0] rdDataA, rdDataB;
  logic [4:0]  wrAddr;
  logic [63:0] wrData;
  logic        write;
  logic        mul_busy;

  logic [63:0] rf [32];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  exec_writeback_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .dst(dst), .imm(imm), .use_imm(use_imm),
    .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .rdDataA(rdDataA), .rdDataB(rdDataB),
    .wrAddr(wrAddr), .wrData(wrData), .write(write), .mul_busy(mul_busy)
  );

  // Register file model
  assign rdDataA = rf[rdAddrA];
  assign rdDataB = rf[rdAddrB];
  always @(posedge clk) if (write) rf[wrAddr] <= wrData;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [15:0] im, input logic ui);
    op = o; src_a = a; src_b = b; dst = d; imm = im; use_imm = ui;
    in_valid = 1'b1;
    checkEq("ready_at_issue", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  int lowCnt;
  int writeCnt;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;
    reset = 1'b1; in_valid = 1'b0; op = 4'd0; src_a = 5'd0; src_b = 5'd0;
    dst = 5'd0; imm = 16'd0; use_imm = 1'b0;

    step();
    checkEq("ready_in_reset", {63'd0, in_ready}, 64'd0);
    step();
    checkEq("rst_write", {63'd0, write}, 64'd0);
    checkEq("rst_wraddr", {59'd0, wrAddr}, 64'd0);
    checkEq("rst_wrdata", wrData, 64'd0);
    checkEq("rst_busy", {63'd0, mul_busy}, 64'd0);
    checkEq("ready_in_reset2", {63'd0, in_ready}, 64'd0);
    reset = 1'b0;
    #1;
    checkEq("ready_after_rst", {63'd0, in_ready}, 64'd1);

    issue(4'd9, 5'd0, 5'd0, 5'd1, 16'hFFFF, 1'b1);
    checkEq("movb_write", {63'd0, write}, 64'd1);
    checkEq("movb_addr", {59'd0, wrAddr}, 64'd1);
    checkEq("movb_data", wrData, 64'hFFFFFFFFFFFFFFFF);

    issue(4'd0, 5'd1, 5'd0, 5'd2, 16'd1, 1'b1);
    checkEq("fwd_add_data", wrData, 64'd0);
    checkEq("fwd_add_addr", {59'd0, wrAddr}, 64'd2);
    issue(4'd1, 5'd2, 5'd1, 5'd3, 16'd0, 1'b0);
    checkEq("fwd_sub_data", wrData, 64'd1);

    issue(4'd9, 5'd0, 5'd0, 5'd5, 16'd1, 1'b1);
    issue(4'd5, 5'd5, 5'd0, 5'd4, 16'd63, 1'b1);
    checkEq("sll_r4", wrData, 64'h8000000000000000);
    issue(4'd7, 5'd4, 5'd0, 5'd6, 16'd63, 1'b1);
    checkEq("sra63", wrData, 64'hFFFFFFFFFFFFFFFF);
    issue(4'd6, 5'd4, 5'd0, 5'd7, 16'd63, 1'b1);
    checkEq("srl63", wrData, 64'd1);
    issue(4'd8, 5'd4, 5'd0, 5'd8, 16'd0, 1'b0);
    checkEq("slt_neg", wrData, 64'd1);
    issue(4'd5, 5'd4, 5'd0, 5'd9, 16'd64, 1'b1);
    checkEq("sll64", wrData, 64'h8000000000000000);
    issue(4'd9, 5'd0, 5'd9, 5'd10, 16'd5, 1'b1);
    checkEq("imm_no_fwd", wrData, 64'd5);
    issue(4'd2, 5'd6, 5'd9, 5'd16, 16'd0, 1'b0);
    checkEq("and_fwd", wrData, 64'h8000000000000000);
    issue(4'd4, 5'd6, 5'd7, 5'd17, 16'd0, 1'b0);
    checkEq("xor", wrData, 64'hFFFFFFFFFFFFFFFE);

    issue(4'd9, 5'd0, 5'd0, 5'd11, 16'd3, 1'b1);
    issue(4'd10, 5'd1, 5'd11, 5'd12, 16'd0, 1'b0);
    checkEq("mul_busy", {63'd0, mul_busy}, 64'd1);
    lowCnt = 0; writeCnt = 0;
    in_valid = 1'b1; op = 4'd9; dst = 5'd20; use_imm = 1'b1; imm = 16'd7;
    while (!in_ready && lowCnt < 200) begin
      lowCnt++;
      if (write) writeCnt++;
      step();
    end
    in_valid = 1'b0;
    checkEq("mul_ready_low", lowCnt, 64'd64);
    checkEq("mul_no_early_wr", writeCnt, 64'd0);
    checkEq("mul_write", {63'd0, write}, 64'd1);
    checkEq("mul_addr", {59'd0, wrAddr}, 64'd12);
    checkEq("mul_data", wrData, 64'hFFFFFFFFFFFFFFFD);
    issue(4'd0, 5'd12, 5'd0, 5'd13, 16'd0, 1'b1);
    checkEq("mul_fwd_add", wrData, 64'hFFFFFFFFFFFFFFFD);

    issue(4'd10, 5'd1, 5'd11, 5'd14, 16'd0, 1'b0);
    for (int i = 0; i < 30; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checkEq("abort_ready", {63'd0, in_ready}, 64'd1);
    checkEq("abort_busy", {63'd0, mul_busy}, 64'd0);
    writeCnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (write) writeCnt++;
      step();
    end
    checkEq("abort_no_write", writeCnt, 64'd0);

    in_valid = 1'b1; op = 4'd9; dst = 5'd15; imm = 16'd9; use_imm = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    checkEq("rst_prio_write", {63'd0, write}, 64'd0);
    #1;

    issue(4'd12, 5'd1, 5'd1, 5'd18, 16'd0, 1'b0);
    checkEq("illegal_write", {63'd0, write}, 64'd0);
    checkEq("illegal_ready", {63'd0, in_ready}, 64'd1);
    step();
    checkEq("illegal_still0", {63'd0, write}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
